// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares a single line-wide memory port between an I-cache (refill only) and
//   a D-cache (refill or write-back). At most one memory transaction is in
//   flight. When both caches request in the same cycle, the winner is the one
//   that was not granted last. A memory access that gets no m_ack ends in a
//   timeout: err pulses together with the owner's ack.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   i_req/i_addr                  I-cache refill request, held until i_ack
//   i_rdata/i_ack                 returned line and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata     D-cache request (d_we=1 is a write-back)
//   d_rdata/d_ack                 returned line and one-cycle completion pulse
//   m_req/m_we/m_addr/m_wdata     memory request, held stable until m_ack
//   m_rdata/m_ack                 memory response, valid in the m_ack cycle
//   err                           one-cycle pulse when the memory timed out
//   owner                         last granted requester (0 = I, 1 = D)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int TMO_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              err,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

    state_t              state_q, state_d;
    logic                m_we_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [LINE_W-1:0]   m_wdata_q;
    logic [LINE_W-1:0]   i_rdata_q, d_rdata_q;
    logic                i_ack_q, d_ack_q, err_q;
    logic                owner_q;
    logic [TMO_W-1:0]    tmo_q;

    logic                tmo_max;
    logic                grant, sel_d, mem_done, mem_tmo;

    assign tmo_max = &tmo_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic. Requests are not looked at in MEM or DONE, so a
    // requester dropping req mid-access does not abort it, and the DONE
    // cycle gives the requester time to drop req after its ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_req || d_req)   state_d = MEM;
            MEM:     if (m_ack || tmo_max) state_d = DONE;
            DONE:                          state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        m_req    = (state_q == MEM);
        grant    = (state_q == IDLE) && (i_req || d_req);
        // With both requesting, the one that is not the last owner wins.
        sel_d    = d_req && (!i_req || !owner_q);
        // m_ack beats a timeout in the same cycle.
        mem_done = (state_q == MEM) && m_ack;
        mem_tmo  = (state_q == MEM) && !m_ack && tmo_max;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            owner_q   <= 1'b1;  // lets the I-cache win the first tie
            tmo_q     <= '0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            err_q   <= 1'b0;

            if (grant) begin
                owner_q   <= sel_d;
                m_we_q    <= sel_d && d_we;
                m_addr_q  <= sel_d ? d_addr : i_addr;
                m_wdata_q <= sel_d ? d_wdata : '0;
                tmo_q     <= '0;
            end

            if ((state_q == MEM) && !m_ack && !tmo_max)
                tmo_q <= tmo_q + TMO_W'(1);

            if (mem_done || mem_tmo) begin
                if (owner_q) d_ack_q <= 1'b1;
                else         i_ack_q <= 1'b1;
            end

            if (mem_tmo) err_q <= 1'b1;

            // Only completed reads update the returned line.
            if (mem_done && !m_we_q) begin
                if (owner_q) d_rdata_q <= m_rdata;
                else         i_rdata_q <= m_rdata;
            end
        end
    end

    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign err     = err_q;
    assign owner   = owner_q;

endmodule
